toggle_checker: RTL and testbench
=================================

TOGGLE_CHECKER -- requirements
Module: toggle_checker

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 4, consecutive alternating transitions required to lock (legal 2..15).
REQ-002 SHALL have parameter LOSS_LEN, default 3, consecutive mismatches that drop lock (legal 1..15).
REQ-003 SHALL have parameter ERR_W, default 8, width of err_count.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port d  input  1  serial data bit to check.
REQ-007 SHALL have port en  input  1  sample enable; d is sampled only on edges where en=1.
REQ-008 SHALL have port clear  input  1  synchronous clear of err_count and bit_count.
REQ-009 SHALL have port locked  output  1  high while in LOCKED.
REQ-010 SHALL have port err  output  1  one-cycle pulse per mismatched sample.
REQ-011 SHALL have port err_count  output  ERR_W  saturating mismatch count.
REQ-012 SHALL have port bit_count  output  16  samples checked while LOCKED, wrapping.
REQ-013 SHALL have port state  output  2  FSM state: IDLE=00, HUNT=01, LOCKED=10, LOST=11.

Function
REQ-014 SHALL hold all state and drive err=0 on any edge with en=0; only the clear action still applies.
REQ-015 SHALL, in IDLE, on the first enabled sample store d as last, set run=0, and go to HUNT.
REQ-016 SHALL, in HUNT, per enabled sample: d!=last -> run+1, else run=0; last<=d.
REQ-017 SHALL go HUNT->LOCKED on the sample where run reaches LOCK_LEN; set expected<=d and miss=0.
REQ-018 SHALL, in LOCKED, per enabled sample: expected<=~expected (flywheel, regardless of d); compare d with ~expected.
REQ-019 SHALL, on a LOCKED match, set miss=0; on a mismatch, set err=1 for the following cycle, increment err_count, and increment miss.
REQ-020 SHALL increment bit_count on every enabled LOCKED sample, wrapping 0xFFFF->0x0000.
REQ-021 SHALL saturate err_count at all-ones; no wrap.
REQ-022 SHALL go LOCKED->LOST on the mismatch where miss reaches LOSS_LEN; that mismatch still counts.
REQ-023 SHALL, in LOST, on the next enabled sample store d as last, set run=0, and go to HUNT; no compare or count.
REQ-024 SHALL register all outputs; locked, state, err and the counters reflect a sample one cycle after its edge.
REQ-025 SHALL give clear priority over increment in the same cycle (result 0); clear SHALL NOT affect FSM, run, miss or expected.

Reset
REQ-026 SHALL, while reset=0, immediately (no clock) force state=IDLE, locked=0, err=0, err_count=0, bit_count=0, run=0, miss=0, last=0, expected=0.
REQ-027 SHALL resume from IDLE on the first enabled sample after reset deasserts; reset mid-LOCKED SHALL discard lock.

Verification
REQ-028 SHALL cover lock acquisition: reset, then en=1, d=0,1,0,1,0 -> state HUNT after sample 1, LOCKED after sample 5, locked=1, err_count=0.
REQ-029 SHALL cover a single flipped bit: while locked, invert one bit -> err high exactly 1 cycle, err_count=1, locked stays 1, later bits match.
REQ-030 SHALL cover loss and relock: while locked, invert 3 consecutive bits -> err_count=3, state LOST then HUNT, locked=0; clean alternation relocks after LOCK_LEN transitions.
REQ-031 SHALL cover no lock: d held at 0 for 50 enabled samples -> state stays HUNT, locked=0, bit_count=0.
REQ-032 SHALL cover saturation and clear: ERR_W=4, 20 isolated errors -> err_count=15; clear together with an error -> err_count=0.
REQ-033 SHALL cover en and reset: en=0 for 10 cycles mid-LOCKED -> all outputs frozen, err=0; reset pulsed low between edges -> outputs 0 before next clk edge.

Source files
------------

// File: rtl/toggle_checker.sv
// Purpose: locks onto an alternating 0/1 bit stream, then flywheel-checks it, counting mismatches and checked bits.
// Latency: one cycle; every output reflects an enabled sample on the edge after it is taken.
// Backpressure: none; en gates sampling, and when en=0 all state holds and err drops.
module toggle_checker #(
  parameter int LOCK_LEN = 4,
  parameter int LOSS_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             en,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      bit_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HUNT   = 2'b01,
    LOCKED = 2'b10,
    LOST   = 2'b11
  } state_t;

  // Thresholds are at most 15, so a 5-bit compare covers run/miss + 1 without overflow.
  localparam logic [4:0] LOCK_LEN_C = 5'(LOCK_LEN);
  localparam logic [4:0] LOSS_LEN_C = 5'(LOSS_LEN);

  state_t     st;
  logic [3:0] run;
  logic [3:0] miss;
  logic       last;
  logic       expected;
  logic [4:0] run_inc;
  logic [4:0] miss_inc;

  assign run_inc  = {1'b0, run} + 5'd1;
  assign miss_inc = {1'b0, miss} + 5'd1;
  assign state    = st;

  // FSM, flywheel compare and counters; clear is applied last so it overrides any increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
      run       <= '0;
      miss      <= '0;
      last      <= 1'b0;
      expected  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (en) begin
        case (st)
          // IDLE and LOST both just seed the hunt with the current bit.
          IDLE, LOST: begin
            last   <= d;
            run    <= '0;
            st     <= HUNT;
            locked <= 1'b0;
          end
          HUNT: begin
            last <= d;
            if (d != last) begin
              run <= run_inc[3:0];
              if (run_inc == LOCK_LEN_C) begin
                st       <= LOCKED;
                locked   <= 1'b1;
                expected <= d;
                miss     <= '0;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: the reference keeps toggling whatever d does.
            expected  <= ~expected;
            bit_count <= bit_count + 16'd1;
            if (d == expected) begin
              err <= 1'b1;
              if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
              end
              miss <= miss_inc[3:0];
              if (miss_inc == LOSS_LEN_C) begin
                st     <= LOST;
                locked <= 1'b0;
              end
            end else begin
              miss <= '0;
            end
          end
          default: begin
            st     <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_checker.sv
// Purpose: directed, table-driven self-checking bench for toggle_checker.
// Latency: checks each sample one cycle after its clock edge.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_toggle_checker;

  logic        clk;
  logic        reset;
  logic        d;
  logic        en;
  logic        clear;
  logic        locked;
  logic        err;
  logic [3:0]  err_count;
  logic [15:0] bit_count;
  logic [1:0]  state;

  int checks;
  int failures;

  toggle_checker #(.LOCK_LEN(4), .LOSS_LEN(3), .ERR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .en        (en),
    .clear     (clear),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .bit_count (bit_count),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          d;
    bit          en;
    bit          clr;
    logic [1:0]  st;
    bit          lk;
    bit          er;
    logic [3:0]  ec;
    logic [15:0] bc;
  } vec_t;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HUNT = 2'b01;
  localparam logic [1:0] S_LOCK = 2'b10;
  localparam logic [1:0] S_LOST = 2'b11;

  vec_t tbl [22];

  function automatic vec_t mk(bit dd, bit ee, bit cc, logic [1:0] s, bit l, bit e,
                              logic [3:0] c, logic [15:0] b);
    vec_t v;
    v.d = dd; v.en = ee; v.clr = cc; v.st = s; v.lk = l; v.er = e; v.ec = c; v.bc = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input bit l, input bit e,
                         input logic [3:0] c, input logic [15:0] b);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".err_count"}, 32'(err_count), 32'(c));
    chk({tag, ".bit_count"}, 32'(bit_count), 32'(b));
  endtask

  task automatic step(input bit dd, input bit ee, input bit cc);
    @(negedge clk);
    d = dd; en = ee; clear = cc;
    @(posedge clk);
    #1;
  endtask

  bit exp_bit;
  logic [15:0] bc_m;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; d = 1'b0; en = 1'b0; clear = 1'b0;

    // Lock, single flip, en freeze, clear while locked, 3-flip loss, relock.
    tbl[0]  = mk(0, 1, 0, S_HUNT, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, S_HUNT, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, S_HUNT, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, S_HUNT, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, S_LOCK, 1, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, S_LOCK, 1, 0, 0, 1);
    tbl[6]  = mk(0, 1, 0, S_LOCK, 1, 0, 0, 2);
    tbl[7]  = mk(0, 1, 0, S_LOCK, 1, 1, 1, 3);
    tbl[8]  = mk(0, 1, 0, S_LOCK, 1, 0, 1, 4);
    tbl[9]  = mk(1, 1, 0, S_LOCK, 1, 0, 1, 5);
    tbl[10] = mk(0, 0, 0, S_LOCK, 1, 0, 1, 5);
    tbl[11] = mk(1, 0, 0, S_LOCK, 1, 0, 1, 5);
    tbl[12] = mk(0, 1, 1, S_LOCK, 1, 0, 0, 0);
    tbl[13] = mk(0, 1, 0, S_LOCK, 1, 1, 1, 1);
    tbl[14] = mk(1, 1, 0, S_LOCK, 1, 1, 2, 2);
    tbl[15] = mk(0, 1, 0, S_LOST, 0, 1, 3, 3);
    tbl[16] = mk(1, 1, 0, S_HUNT, 0, 0, 3, 3);
    tbl[17] = mk(0, 1, 0, S_HUNT, 0, 0, 3, 3);
    tbl[18] = mk(1, 1, 0, S_HUNT, 0, 0, 3, 3);
    tbl[19] = mk(0, 1, 0, S_HUNT, 0, 0, 3, 3);
    tbl[20] = mk(1, 1, 0, S_LOCK, 1, 0, 3, 3);
    tbl[21] = mk(0, 1, 0, S_LOCK, 1, 0, 3, 4);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", S_IDLE, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 0);
    chk_all("idle_no_en", S_IDLE, 0, 0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].d, tbl[i].en, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].lk, tbl[i].er, tbl[i].ec, tbl[i].bc);
    end

    // After vec21 the flywheel reference is 0, so the next wanted bit is 1.
    exp_bit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(i[0], 0, 0);
      chk_all($sformatf("freeze%0d", i), S_LOCK, 1, 0, 3, 4);
    end

    // 20 isolated errors, each followed by a good bit: err_count saturates at 15.
    bc_m = 16'd4;
    for (int i = 0; i < 20; i++) begin
      step(exp_bit, 1, 0);
      exp_bit = ~exp_bit;
      bc_m++;
      chk($sformatf("sat_err%0d", i), 32'(err), 32'd1);
      step(~exp_bit, 1, 0);
      exp_bit = ~exp_bit;
      bc_m++;
      chk($sformatf("sat_ok%0d", i), 32'(err), 32'd0);
    end
    chk_all("saturated", S_LOCK, 1, 0, 15, bc_m);

    // Clear in the same cycle as an error: clear wins, err still pulses.
    step(exp_bit, 1, 1);
    exp_bit = ~exp_bit;
    chk_all("clear_vs_err", S_LOCK, 1, 1, 0, 0);
    step(~exp_bit, 1, 0);
    exp_bit = ~exp_bit;
    chk_all("after_clear", S_LOCK, 1, 0, 0, 1);
    step(exp_bit, 1, 0);
    exp_bit = ~exp_bit;
    chk_all("pre_reset", S_LOCK, 1, 1, 1, 2);

    // Asynchronous reset between edges clears everything before the next edge.
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", S_IDLE, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 1, 0);
    chk_all("resume_hunt", S_HUNT, 0, 0, 0, 0);

    // Constant input never locks.
    for (int i = 0; i < 50; i++) begin
      step(0, 1, 0);
      chk($sformatf("nolock_state%0d", i), 32'(state), 32'(S_HUNT));
    end
    chk_all("nolock_end", S_HUNT, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
